fios_res_collector: RTL

//  Downstream result stage of the FIOS Montgomery multiplier. Captures the s result limbs

---
 rtl/fios_res_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fios_res_collector.sv
// Result collector for the FIOS Montgomery multiplier.
// Buffers the s result limbs pushed by the multiplier and waits for done.
// Then replays the limbs, least significant first, over a valid/ready port.
// Any out-of-order push or done raises a sticky error flag.
module fios_res_collector #(
  parameter int s     = 8,
  parameter int WIDTH = 17
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] RES_i,
  input  logic             RES_push_i,
  input  logic             done_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_last_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CW = $clog2(s + 1);
  localparam int AW = (s > 1) ? $clog2(s) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(s);
  localparam logic [CW-1:0] CNT_LAST = CW'(s - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WAIT_DONE,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    wr_cnt_inc;
  logic             err_q, err_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             handshake;
  logic             full_after_push;
  logic [WIDTH-1:0] res_mem_q [s];

  // Next-state, counter and error logic for the collect/drain sequence.
  always_comb begin
    state_d         = state_q;
    wr_cnt_d        = wr_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    err_d           = err_q;
    mem_we          = 1'b0;
    mem_waddr       = wr_cnt_q[AW-1:0];
    wr_cnt_inc      = wr_cnt_q + CW'(1);
    handshake       = (state_q == ST_DRAIN) && res_ready_i;
    full_after_push = RES_push_i && (wr_cnt_inc == CNT_FULL);

    unique case (state_q)
      ST_IDLE: begin
        if (RES_push_i) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          if (done_i) begin
            // A single limb can never be a complete result.
            err_d    = 1'b1;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = CW'(1);
            state_d  = ST_COLLECT;
          end
        end else if (done_i) begin
          err_d = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (RES_push_i) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_inc;
        end
        if (done_i) begin
          if (full_after_push) begin
            // Last push and done together is the fast path straight to output.
            state_d  = ST_DRAIN;
            rd_cnt_d = '0;
          end else begin
            // Early done: discard the partial result.
            err_d    = 1'b1;
            wr_cnt_d = '0;
            state_d  = ST_IDLE;
          end
        end else if (full_after_push) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (RES_push_i) begin
          err_d = 1'b1;
        end
        if (done_i) begin
          state_d  = ST_DRAIN;
          rd_cnt_d = '0;
        end
      end

      ST_DRAIN: begin
        if (RES_push_i) begin
          err_d = 1'b1;
        end
        if (handshake) begin
          if (rd_cnt_q == CNT_LAST) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = ST_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state register; reset aborts any collect or drain in progress.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  // Limb buffer; contents need no reset because only fully written results are read.
  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      res_mem_q[mem_waddr] <= RES_i;
    end
  end

  // Downstream port decode; data is forced to zero outside DRAIN.
  always_comb begin
    res_valid_o = (state_q == ST_DRAIN);
    res_last_o  = (state_q == ST_DRAIN) && (rd_cnt_q == CNT_LAST);
    res_data_o  = (state_q == ST_DRAIN) ? res_mem_q[rd_cnt_q[AW-1:0]] : '0;
    busy_o      = (state_q != ST_IDLE);
    err_o       = err_q;
  end

endmodule
